msgdma_st_dispatch: RTL and testbench



---
 rtl/msgdma_dispatch_pkg.sv | 17 +
 rtl/st_skid_buf2.sv | 55 +++++
 rtl/msgdma_st_dispatch.sv | 127 ++++++++++++
 tb/tb_msgdma_st_dispatch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msgdma_dispatch_pkg.sv
// msgDMA stream dispatcher: shared types and helpers.
// FSM states, counter width and channel-index width helper.
package msgdma_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    STREAM
  } state_t;

  localparam int BEAT_CNT_W = 8;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/st_skid_buf2.sv
// Two-entry valid/ready buffer; head is fully registered.
// Pushes are dropped when full, pops are ignored when empty.
module st_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] push_data,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   cnt
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_push;
  logic         do_pop;

  assign do_push    = push && (cnt != 2'd2);
  assign do_pop     = pop && (cnt != 2'd0);
  assign head_data  = slot0;
  assign head_valid = (cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) slot0 <= slot1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/msgdma_st_dispatch.sv
// Round-robin burst dispatcher sharing one msgDMA stream source
// among NUM_CH consumers through a registered 2-entry buffer.
module msgdma_st_dispatch
  import msgdma_dispatch_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [NUM_CH-1:0]         m_valid,
  input  logic [NUM_CH-1:0]         m_ready,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic [ch_w(NUM_CH)-1:0]   cur_ch,
  output logic                      burst_done
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int PW   = DATA_W + CH_W;

  state_t                  state;
  state_t                  state_nx;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic [CH_W-1:0]         last_grant;
  logic [CH_W:0]           pick;
  logic                    accept;
  logic [PW-1:0]           head;
  logic                    head_valid;
  logic [CH_W-1:0]         head_ch;
  logic [1:0]              buf_cnt;
  logic                    pop;

  // First enabled channel after `last`, searching cyclically.
  function automatic logic [CH_W:0] rr_pick(
    input logic [CH_W-1:0]   last,
    input logic [NUM_CH-1:0] en
  );
    logic            found;
    logic [CH_W-1:0] sel;
    int              idx;
    found = 1'b0;
    sel   = last;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      if (!found && en[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  assign pick   = rr_pick(last_grant, ch_enable);
  assign accept = s_valid && s_ready;

  always_comb begin
    state_nx   = state;
    s_ready    = 1'b0;
    burst_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_valid && (|ch_enable)) state_nx = SELECT;
      end
      SELECT: begin
        state_nx = pick[CH_W] ? STREAM : IDLE;
      end
      STREAM: begin
        s_ready = (buf_cnt < 2'd2);
        // Accepting the final beat implies s_valid is still high.
        if (s_valid && s_ready &&
            beat_cnt == BEAT_CNT_W'(BURST_LEN - 1)) begin
          burst_done = 1'b1;
          state_nx   = SELECT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_ch     <= '0;
      beat_cnt   <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      state <= state_nx;
      if (state == SELECT) begin
        beat_cnt <= '0;
        if (pick[CH_W]) cur_ch <= pick[CH_W-1:0];
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (burst_done) last_grant <= cur_ch;
    end
  end

  st_skid_buf2 #(
    .W(PW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push_data ({cur_ch, s_data}),
    .push      (accept),
    .pop       (pop),
    .head_data (head),
    .head_valid(head_valid),
    .cnt       (buf_cnt)
  );

  assign head_ch = head[PW-1:DATA_W];
  assign m_data  = head[DATA_W-1:0];
  assign pop     = head_valid && m_ready[head_ch];

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_valid[i] = head_valid && (head_ch == CH_W'(i));
    end
  end

endmodule

// File: tb/tb_msgdma_st_dispatch.sv
// Directed bench for msgdma_st_dispatch with a beat scoreboard.
// Expected {channel, data} pushed on input handshake, popped on output.
module tb_msgdma_st_dispatch;

  localparam int DW = 128;
  localparam int NC = 4;
  localparam int BL = 16;

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [NC-1:0] m_valid;
  logic [NC-1:0] m_ready = '1;
  logic [NC-1:0] ch_enable = '1;
  logic [1:0]    cur_ch;
  logic          burst_done;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            bd_cnt = 0;
  int            in_acc = 0;
  logic [NC-1:0] seen = '0;
  logic          held = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic [NC-1:0] held_v = '0;

  always #5 clk = ~clk;

  msgdma_st_dispatch #(
    .DATA_W   (DW),
    .NUM_CH   (NC),
    .BURST_LEN(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .ch_enable (ch_enable),
    .cur_ch    (cur_ch),
    .burst_done(burst_done)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    int   ch;
    exp_t e;
    if (reset) begin
      held = 1'b0;
      return;
    end
    if (burst_done) bd_cnt++;
    if (s_valid && s_ready) in_acc++;
    seen |= m_valid;
    if (m_valid == '0) begin
      held = 1'b0;
      return;
    end
    chk("onehot", DW'($onehot(m_valid)), DW'(1));
    if (held) begin
      chk("hold_data", m_data, held_d);
      chk("hold_valid", DW'(m_valid), DW'(held_v));
    end
    ch = 0;
    for (int i = 0; i < NC; i++) if (m_valid[i]) ch = i;
    if ((m_valid & m_ready) != '0) begin
      held = 1'b0;
      chk("sb_nonempty", DW'(q.size() > 0), DW'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_ch", DW'(ch), DW'(e.ch));
        chk("out_data", m_data, e.d);
      end
    end else begin
      held   = 1'b1;
      held_d = m_data;
      held_v = m_valid;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    tick();
    tick();
    q.delete();
    held  = 1'b0;
    reset = 1'b0;
  endtask

  // Leaves s_valid high after the last beat.
  task automatic send(input int n, input int base, input int ch);
    int t;
    for (int k = 0; k < n; k++) begin
      s_data  = DW'(base + k);
      s_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (s_ready) begin
          q.push_back(exp_t'{ch, s_data});
          break;
        end
        t++;
        if (t > 40) begin
          chk("accept_timeout", DW'(0), DW'(1));
          break;
        end
      end
      tick();
    end
  endtask

  task automatic drain();
    int t;
    s_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    chk("drained", DW'(q.size()), DW'(0));
  endtask

  initial begin
    int            a0;
    logic          ok;
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    do_reset();
    chk("rst_m_valid", DW'(m_valid), DW'(0));
    chk("rst_s_ready", DW'(s_ready), DW'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_cur_ch", DW'(cur_ch), DW'(0));
    chk("rst_burst_done", DW'(burst_done), DW'(0));

    // Basic: 40 beats across channels 0, 1, 2.
    bd_cnt = 0;
    send(16, 0, 0);
    send(16, 16, 1);
    send(8, 32, 2);
    drain();
    chk("basic_bursts", DW'(bd_cnt), DW'(2));
    chk("basic_cur_ch", DW'(cur_ch), DW'(2));

    // Sparse enable: grants alternate 1, 3.
    do_reset();
    ch_enable = 4'b1010;
    seen = '0;
    send(16, 100, 1);
    send(16, 200, 3);
    send(16, 300, 1);
    send(16, 400, 3);
    drain();
    chk("sparse_seen", DW'(seen), DW'(4'b1010));

    // Backpressure on channel 0 for 5 cycles mid-burst.
    do_reset();
    ch_enable = '1;
    fork
      send(16, 500, 0);
      begin
        repeat (4) tick();
        m_ready = 4'b1110;
        a0 = in_acc;
        repeat (5) tick();
        chk("bp_s_ready", DW'(s_ready), DW'(0));
        chk("bp_acc_le2", DW'((in_acc - a0) <= 2), DW'(1));
        m_ready = '1;
      end
    join
    drain();

    // Enable for channel 0 removed after beat 3.
    do_reset();
    ch_enable = '1;
    send(4, 600, 0);
    ch_enable = 4'b1110;
    send(12, 604, 0);
    send(4, 616, 1);
    drain();
    chk("en_drop_cur_ch", DW'(cur_ch), DW'(1));

    // All channels disabled: source stalls until channel 2 enabled.
    do_reset();
    ch_enable = '0;
    s_valid = 1'b1;
    s_data = DW'(32'hABCD);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_ready !== 1'b0 || m_valid !== '0) ok = 1'b0;
    end
    chk("all_off_stall", DW'(ok), DW'(1));
    ch_enable = 4'b0100;
    q.push_back(exp_t'{2, s_data});
    repeat (3) tick();
    chk("en_latency_valid", DW'(m_valid), DW'(4'b0100));
    s_valid = 1'b0;
    drain();

    // Reset with the buffer full.
    do_reset();
    ch_enable = '1;
    send(5, 700, 0);
    m_ready = '0;
    send(1, 705, 0);
    s_data = DW'(706);
    reset = 1'b1;
    tick();
    chk("rst_mid_m_valid", DW'(m_valid), DW'(0));
    chk("rst_mid_s_ready", DW'(s_ready), DW'(0));
    s_valid = 1'b0;
    q.delete();
    held = 1'b0;
    tick();
    reset = 1'b0;
    m_ready = '1;
    send(16, 800, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
